// File: rtl/mux_pkg.sv
// Shared constants and the parameter sanity check for the word multiplexer.
package mux_pkg;

    localparam int MUX_N_MIN = 2;

    // True when N words can all be addressed by a SEL_W-bit select.
    function automatic bit mux_params_ok(input int n, input int sel_w);
        return (n >= MUX_N_MIN) && ((1 << sel_w) >= n);
    endfunction

endpackage

// File: rtl/mux_if.sv
// Select/data bundle between the datapath controller and the word multiplexer.
interface mux_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
);
    logic [N*WIDTH-1:0] mux_in;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   mux_out;

    modport master (output mux_in, output sel, input mux_out);
    modport slave  (input mux_in, input sel, output mux_out);
endinterface

// File: rtl/mux_pipe_reg.sv
// WIDTH-bit output register with synchronous active-high clear.
module mux_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else     r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/mux.sv
// N-to-1 word multiplexer; combinational or one-cycle registered output.
module mux
    import mux_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int N       = 4,
    parameter int SEL_W   = 2,
    parameter int OUT_REG = 0
) (
    input logic  clk,
    input logic  rst,
    mux_if.slave bus
);
    if (!mux_params_ok(N, SEL_W)) begin : g_param_err
        $fatal(1, "mux: need N >= 2 and 2**SEL_W >= N (N=%0d SEL_W=%0d)", N, SEL_W);
    end

    // Table spans every select code; codes at or above N stay zero.
    logic [WIDTH-1:0] w_word_tbl [1 << SEL_W];
    logic [WIDTH-1:0] w_sel_word;
    logic [WIDTH-1:0] w_out;

    always_comb begin
        w_word_tbl = '{default: '0};
        for (int k = 0; k < N; k++) begin
            w_word_tbl[k] = bus.mux_in[k*WIDTH +: WIDTH];
        end
    end

    assign w_sel_word = w_word_tbl[bus.sel];

    if (OUT_REG != 0) begin : g_reg
        mux_pipe_reg #(.WIDTH(WIDTH)) u_pipe_reg (
            .clk (clk),
            .rst (rst),
            .i_d (w_sel_word),
            .o_q (w_out)
        );
    end else begin : g_comb
        logic w_unused_ctl;
        assign w_unused_ctl = clk ^ rst;
        assign w_out        = w_sel_word;
    end

    assign bus.mux_out = w_out;
endmodule

// File: tb/tb_mux.sv
// Directed bench for mux: combinational, registered and non-power-of-2 builds.
module tb_mux;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mux_if #(.WIDTH(8),  .N(4), .SEL_W(2)) if_comb ();
    mux_if #(.WIDTH(8),  .N(4), .SEL_W(2)) if_reg ();
    mux_if #(.WIDTH(16), .N(3), .SEL_W(2)) if_n3 ();

    mux #(.WIDTH(8),  .N(4), .SEL_W(2), .OUT_REG(0)) u_comb (.clk(clk), .rst(rst), .bus(if_comb));
    mux #(.WIDTH(8),  .N(4), .SEL_W(2), .OUT_REG(1)) u_reg  (.clk(clk), .rst(rst), .bus(if_reg));
    mux #(.WIDTH(16), .N(3), .SEL_W(2), .OUT_REG(0)) u_n3   (.clk(clk), .rst(rst), .bus(if_n3));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b0;
        if_comb.mux_in = {8'd1, 8'd11, 8'd3, 8'd5};
        if_comb.sel    = 2'd2;
        if_reg.mux_in  = {8'd1, 8'd11, 8'd3, 8'd5};
        if_reg.sel     = 2'd1;
        if_n3.mux_in   = {16'hFFFF, 16'h1234, 16'hA5A5};
        if_n3.sel      = 2'd0;

        // Combinational build, no clock edge involved.
        #1;
        check("comb_sel2", {8'h00, if_comb.mux_out}, 16'd11);
        if_comb.sel = 2'd0; #1;
        check("comb_sel0", {8'h00, if_comb.mux_out}, 16'd5);
        if_comb.sel = 2'd1; #1;
        check("comb_sel1", {8'h00, if_comb.mux_out}, 16'd3);
        if_comb.sel = 2'd3; #1;
        check("comb_sel3", {8'h00, if_comb.mux_out}, 16'd1);
        if_comb.mux_in = {8'hFF, 8'd11, 8'd3, 8'd5}; #1;
        check("comb_top_change", {8'h00, if_comb.mux_out}, 16'h00FF);

        // Non-power-of-2 build: code 3 is out of range.
        if_n3.sel = 2'd0; #1;
        check("n3_sel0", if_n3.mux_out, 16'hA5A5);
        if_n3.sel = 2'd1; #1;
        check("n3_sel1", if_n3.mux_out, 16'h1234);
        if_n3.sel = 2'd2; #1;
        check("n3_sel2", if_n3.mux_out, 16'hFFFF);
        if_n3.sel = 2'd3; #1;
        check("n3_sel3_oor", if_n3.mux_out, 16'h0000);

        // Registered build: reset held for two edges.
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reg_reset", {8'h00, if_reg.mux_out}, 16'd0);
        rst = 1'b0; #1;
        check("reg_not_before_edge", {8'h00, if_reg.mux_out}, 16'd0);
        @(posedge clk); #1;
        check("reg_first_sel1", {8'h00, if_reg.mux_out}, 16'd3);

        // Back-to-back selects, one-cycle lag.
        if_reg.sel = 2'd0;
        @(posedge clk); #1;
        check("reg_seq0", {8'h00, if_reg.mux_out}, 16'd5);
        if_reg.sel = 2'd1; #1;
        check("reg_seq_lag", {8'h00, if_reg.mux_out}, 16'd5);
        @(posedge clk); #1;
        check("reg_seq1", {8'h00, if_reg.mux_out}, 16'd3);
        if_reg.sel = 2'd2;
        @(posedge clk); #1;
        check("reg_seq2", {8'h00, if_reg.mux_out}, 16'd11);
        if_reg.sel = 2'd3;
        @(posedge clk); #1;
        check("reg_seq3", {8'h00, if_reg.mux_out}, 16'd1);

        // Reset mid-stream with sel held at 3.
        rst = 1'b1;
        @(posedge clk); #1;
        check("reg_mid_reset", {8'h00, if_reg.mux_out}, 16'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reg_after_release", {8'h00, if_reg.mux_out}, 16'd1);

        // Combinational build ignores clock and reset activity.
        check("comb_ignores_clk", {8'h00, if_comb.mux_out}, 16'h00FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
